// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/operand/execute controller for an external combinational accumulator ALU
// Ports: clk/rst_n (async active-low); start/prog_len/done run control; imem_* instruction fetch handshake;
// dmem_* data memory read/write; alu_* drive and results of the external ALU; acc/pc/flags architectural state.
// Option: define ALU_SEQ_CARRY_CHAIN_EN to feed the c flag into alu_ci during kADD.
module alu_sequencer #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [PC_W-1:0] prog_len,
  output logic            done,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [8:0]      imem_data,
  output logic [7:0]      dmem_addr,
  output logic            dmem_rd_en,
  input  logic [7:0]      dmem_rdata,
  output logic            dmem_wr_en,
  output logic [7:0]      dmem_wdata,
  output logic [3:0]      alu_op,
  output logic [7:0]      alu_a,
  output logic [7:0]      alu_acc,
  output logic            alu_ci,
  input  logic [7:0]      alu_res,
  input  logic            alu_co,
  input  logic            alu_z,
  input  logic            alu_neg,
  output logic [7:0]      acc,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      flags
);
  localparam logic [3:0] kNOP = 4'd0, kLDI = 4'd1, kADD = 4'd2, kSUB = 4'd3,
                         kAND = 4'd4, kXOR = 4'd5, kSHL = 4'd6, kSHR = 4'd7,
                         kLDR = 4'd8, kMLD = 4'd9, kMST = 4'd10, kSTR = 4'd11,
                         kJMP = 4'd12, kBRZ = 4'd13, kBRN = 4'd14, kCLR = 4'd15;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MEMRD, S_EXEC, S_HALT} state_t;
  state_t          r_state, w_next;
  logic [8:0]      r_ir;
  logic [7:0]      r_acc;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [2:0]      r_flags;
  logic [3:0]      w_op;
  logic [4:0]      w_imm;
  logic            w_exec, w_mem_op, w_imm_op, w_store, w_wr_acc, w_taken;
  function automatic logic is_mem(input logic [3:0] op);
    return op == kADD || op == kSUB || op == kAND || op == kXOR || op == kLDR || op == kMLD;
  endfunction
  assign w_op     = r_ir[8:5];
  assign w_imm    = r_ir[4:0];
  assign w_exec   = r_state == S_EXEC;
  assign w_mem_op = is_mem(w_op);
  assign w_imm_op = w_op == kLDI || w_op == kSHL || w_op == kSHR;
  assign w_store  = w_op == kMST || w_op == kSTR;
  assign w_wr_acc = !(w_store || w_op == kJMP || w_op == kBRZ || w_op == kBRN);
  // branches test the registered flags, never the live ALU outputs
  assign w_taken  = (w_op == kBRZ && r_flags[1]) || (w_op == kBRN && r_flags[0]);
  assign w_pc_next = w_op == kJMP ? PC_W'(w_imm)
                   : w_taken     ? r_pc + {{(PC_W-5){w_imm[4]}}, w_imm}
                   :               r_pc + PC_W'(1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_FETCH : S_IDLE;
      S_FETCH: w_next = !imem_valid ? S_FETCH : is_mem(imem_data[8:5]) ? S_MEMRD : S_EXEC;
      S_MEMRD: w_next = S_EXEC;
      S_EXEC:  w_next = r_pc == prog_len ? S_HALT : S_FETCH;
      S_HALT:  w_next = start ? S_HALT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_acc   <= '0;
      r_pc    <= '0;
      r_flags <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_acc   <= '0;
        r_pc    <= '0;
        r_flags <= '0;
      end
      if (r_state == S_FETCH && imem_valid) r_ir <= imem_data;
      if (w_exec) begin
        r_pc <= w_pc_next;
        if (w_wr_acc) begin
          r_acc   <= alu_res;
          r_flags <= w_op == kCLR ? 3'b000 : {alu_co, alu_z, alu_neg};
        end
      end
    end
  end
  assign done       = r_state == S_HALT;
  assign imem_req   = r_state == S_FETCH;
  assign imem_addr  = r_pc;
  assign dmem_addr  = {3'b000, w_imm};
  assign dmem_rd_en = r_state == S_MEMRD;
  assign dmem_wr_en = w_exec && w_store;
  assign dmem_wdata = r_acc;
  assign alu_op     = w_exec ? w_op : 4'd0;
  assign alu_a      = !w_exec ? 8'd0 : w_imm_op ? {3'b000, w_imm} : w_mem_op ? dmem_rdata : 8'd0;
  assign alu_acc    = w_exec ? r_acc : 8'd0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
  assign alu_ci     = w_exec && w_op == kADD && r_flags[2];
`else
  assign alu_ci     = 1'b0;
`endif
  assign acc        = r_acc;
  assign pc         = r_pc;
  assign flags      = r_flags;
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle control sequencer that drives the accumulator ALU from its operand/opcode side. It fetches 9-bit instructions over a request/valid handshake and sources the ALU operand from an immediate or from data memory. It registers the accumulator, carry and Z/N flags from the ALU outputs and updates the PC, including flag-conditional branches. It sits between instruction/data memories and the combinational ALU and owns all architectural state.

## Interface
- PC_W, 8: program counter width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE only.
- prog_len  in  PC_W  last PC to execute.
- done  out  1  high in HALT.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_W  equals pc.
- imem_valid  in  1  instruction present this cycle.
- imem_data  in  9  {op[3:0], imm[4:0]}.
- dmem_addr  out  8  {3'b0, imm}.
- dmem_rd_en  out  1  read strobe; data arrives next cycle.
- dmem_rdata  in  8  read data.
- dmem_wr_en  out  1  one-cycle write strobe.
- dmem_wdata  out  8  equals acc.
- alu_op  out  4  opcode from definitions package.
- alu_a  out  8  operand.
- alu_acc  out  8  equals acc register.
- alu_ci  out  1  carry in.
- alu_res, alu_co, alu_z, alu_neg  in  8/1/1/1  ALU results.
- acc  out  8  accumulator register.
- pc  out  PC_W  program counter.
- flags  out  3  {c, z, n}.

## Operation
- States: IDLE, FETCH, MEMRD, EXEC, HALT.
- IDLE→FETCH when start=1. pc=0, acc=0, flags=0.
- FETCH: imem_req=1 until imem_valid=1. IR is captured in that cycle. Next state is MEMRD for kADD/kSUB/kAND/kXOR/kLDR/kMLD, otherwise EXEC.
- MEMRD: dmem_rd_en=1 for exactly one cycle. Next state is EXEC, and alu_a=dmem_rdata in EXEC.
- EXEC: alu_op=IR.op.
  - alu_a source: zero-extended imm for kLDI/kSHL/kSHR; dmem_rdata for memory ops; 0 otherwise.
  - acc←alu_res and {c,z,n}←{alu_co,alu_z,alu_neg} for all ops except kJMP/kBRN/kBRZ/kMST/kSTR.
  - kMST/kSTR: dmem_wr_en=1, dmem_wdata=acc, acc unchanged.
  - kCLR: c,z,n←0.
- PC update in EXEC:
  - kJMP: pc←zero-extended imm.
  - kBRZ: pc←pc+sext(imm) if z=1.
  - kBRN: pc←pc+sext(imm) if n=1.
  - Otherwise pc←pc+1, with modulo 2^PC_W wrap.
  - Branch flags are the registered values, not the current ALU outputs.
- After EXEC: go to HALT if the pre-update pc == prog_len, else FETCH.
- HALT: done=1. Go to IDLE when start=0.
- start is ignored outside IDLE and HALT.
- Reset (async, any state): state=IDLE. Every output is 0: acc, pc, flags, done, imem_req, dmem_rd_en, dmem_wr_en, alu_op, alu_a, alu_ci. Any in-flight fetch or write is abandoned, and dmem_wr_en never glitches high.

## Timing
- Immediate/branch/store instruction: 2 cycles (FETCH+EXEC) with zero-wait imem_valid.
- Memory-operand instruction: 3 cycles.
- Every imem wait cycle adds one cycle.
- acc, flags and pc are visible the cycle after EXEC.
- dmem_wr_en is asserted only during EXEC, with address and data stable in the same cycle.
- alu_* outputs are combinational from IR, the state and the registers. They are 0 outside EXEC.

## Configuration
- ALU_SEQ_CARRY_CHAIN_EN defined: alu_ci=c register during kADD, allowing multi-byte add chains.
- Not defined: alu_ci=0 always. The c flag is still recorded.

## Test plan
- Program LDI 5, ADD [3] with dmem[3]=0x0A, prog_len=1 → acc=0x0F, z=0, done=1 after 5 cycles.
- LDI 0 then BRZ imm=-1 (5'h1F) → z=1, pc returns to 0. With LDI 1 instead, pc=2.
- ADD [0] with acc=0xFF and dmem[0]=0x01 → acc=0x00, c=1, z=1. A following ADD [1] with dmem[1]=0 gives acc=0x01 with carry-chain enabled, 0x00 without.
- LDI 7, MST [4] → single-cycle dmem_wr_en, addr=0x04, wdata=0x07.
- imem_valid held low for 3 cycles → FETCH holds imem_req=1 and imem_addr stable. Capture occurs on valid.
- Assert rst_n=0 in MEMRD → all outputs 0 immediately, state IDLE. start=1 after release restarts at pc=0.
